vcounter_sync: RTL and testbench

Vertical line counter and sync/blanking generator for the discrete-logic Pong core. Consumes the horizontal counter's `hreset` pulse and `h16/h32/h64` taps, counts 262 lines per frame, and produces `vreset`, horizontal and vertical blanking, horizontal and vertical sync, and composite sync. The video mixer, the paddle/ball vertical logic and the score display all read these outputs.

---
 rtl/vcounter_sync.sv | 140 ++++++++++++++
 tb/tb_vcounter_sync.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcounter_sync.sv
// ---------------------------------------------------------------------------
// vcounter_sync
//
// Vertical line counter and sync/blanking generator for the discrete-logic
// Pong core. Counts V_TOTAL lines per frame, advancing once for every clock
// in which the horizontal counter's hreset pulse is high. It also generates
// horizontal/vertical blanking, horizontal/vertical sync and composite sync.
//
// Ports
//   clk7_159  in   pixel clock (7.159 MHz), all registers on rising edge
//   reset     in   asynchronous, active-high reset
//   hreset    in   line-end pulse from the horizontal counter
//   h16/h32/h64 in horizontal count taps (stable at posedge)
//   vcnt      out  vertical count 0..V_TOTAL-1 (vcnt[0] = v1, vcnt[8] = v256)
//   vreset    out  one-clock pulse when vcnt wraps to 0; _vreset complement
//   hblank    out  horizontal blanking; _hblank complement
//   vblank    out  vertical blanking; _vblank complement
//   hsync     out  horizontal sync, active-high
//   vsync     out  vertical sync, active-high
//   _sync     out  composite sync, active-low, serrated during vsync
// ---------------------------------------------------------------------------
module vcounter_sync #(
  parameter int V_TOTAL     = 262,
  parameter int VBLANK_END  = 16,
  parameter int VSYNC_START = 4,
  parameter int VSYNC_END   = 8,
  parameter int HBLANK_END  = 80
) (
  input  logic       clk7_159,
  input  logic       reset,
  input  logic       hreset,
  input  logic       h16,
  input  logic       h32,
  input  logic       h64,
  output logic [8:0] vcnt,
  output logic       vreset,
  output logic       _vreset,
  output logic       hblank,
  output logic       _hblank,
  output logic       vblank,
  output logic       _vblank,
  output logic       hsync,
  output logic       vsync,
  output logic       _sync
);

  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] VB_END   = 9'(VBLANK_END);
  localparam logic [8:0] VS_START = 9'(VSYNC_START);
  localparam logic [8:0] VS_END   = 9'(VSYNC_END);
  localparam logic [6:0] HB_END   = 7'(HBLANK_END);

  // Only the h16/h32/h64 taps are available, so the hblank end count is
  // decoded as the AND of the taps that are set in HBLANK_END (80 -> h16&h64).
  // Lower count bits are not visible here; the decode fires on the first h
  // value with those taps set, which is exactly HBLANK_END for 80.
  logic hblank_clear;

  always_comb begin
    hblank_clear = 1'b1;
    if (HB_END[4]) hblank_clear = hblank_clear & h16;
    if (HB_END[5]) hblank_clear = hblank_clear & h32;
    if (HB_END[6]) hblank_clear = hblank_clear & h64;
  end

  // Next-state logic
  logic       wrap;
  logic [8:0] vcnt_next;
  logic       vreset_next;
  logic       hblank_next;
  logic       hsync_next;
  logic       vblank_next;
  logic       vsync_next;

  always_comb begin
    wrap        = hreset && (vcnt == V_LAST);
    vcnt_next   = vcnt;
    vreset_next = 1'b0;
    hblank_next = hblank;
    vblank_next = vblank;

    // Line advance: step the vertical count, wrapping at the frame end.
    if (hreset) begin
      if (wrap) begin
        vcnt_next   = 9'd0;
        vreset_next = 1'b1;
      end else begin
        vcnt_next = vcnt + 9'd1;
      end
    end

    // Set on line advance wins over the clear decode at the same edge.
    if (hreset) begin
      hblank_next = 1'b1;
    end else if (hblank_clear) begin
      hblank_next = 1'b0;
    end

    // hsync is a window inside hblank: h = 32..63.
    hsync_next = hblank & h32 & ~h64;

    // Vertical blanking brackets lines 0..VBLANK_END-1.
    if (wrap) begin
      vblank_next = 1'b1;
    end else if (hreset && (vcnt_next == VB_END)) begin
      vblank_next = 1'b0;
    end

    // vsync follows the next count so it moves on the same edge as vcnt.
    vsync_next = vblank && (vcnt_next >= VS_START) && (vcnt_next < VS_END);
  end

  // State registers
  always_ff @(posedge clk7_159 or posedge reset) begin
    if (reset) begin
      vcnt   <= 9'd0;
      vreset <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else begin
      vcnt   <= vcnt_next;
      vreset <= vreset_next;
      hblank <= hblank_next;
      vblank <= vblank_next;
      hsync  <= hsync_next;
      vsync  <= vsync_next;
    end
  end

  // Complement and composite outputs
  assign _vreset = ~vreset;
  assign _hblank = ~hblank;
  assign _vblank = ~vblank;
  // Equal hsync/vsync levels give 1: outside vsync _sync = ~hsync, during
  // vsync the hsync pulses show up inverted (serrations).
  assign _sync   = ~(hsync ^ vsync);

endmodule

// File: tb/tb_vcounter_sync.sv
module tb_vcounter_sync;

  logic       clk;
  logic       reset;
  logic       hreset;
  logic       h16;
  logic       h32;
  logic       h64;
  logic [8:0] vcnt;
  logic       vreset;
  logic       vreset_n;
  logic       hblank;
  logic       hblank_n;
  logic       vblank;
  logic       vblank_n;
  logic       hsync;
  logic       vsync;
  logic       sync_n;

  vcounter_sync dut (
    .clk7_159 (clk),
    .reset    (reset),
    .hreset   (hreset),
    .h16      (h16),
    .h32      (h32),
    .h64      (h64),
    .vcnt     (vcnt),
    .vreset   (vreset),
    ._vreset  (vreset_n),
    .hblank   (hblank),
    ._hblank  (hblank_n),
    .vblank   (vblank),
    ._vblank  (vblank_n),
    .hsync    (hsync),
    .vsync    (vsync),
    ._sync    (sync_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;

  // Behavioural reference: line number plus the two horizontal flags.
  // vblank and vsync follow from the line number alone.
  int m_vcnt;
  bit m_hblank;
  bit m_hsync;
  bit m_vreset;

  logic [17:0] dut_vec;
  assign dut_vec = {vcnt, vreset, vreset_n, hblank, hblank_n,
                    vblank, vblank_n, hsync, vsync, sync_n};

  localparam logic [17:0] RESET_VEC = {9'd0, 1'b0, 1'b1, 1'b1, 1'b0,
                                       1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc_no, got, exp);
    end
  endtask

  function automatic logic [17:0] model_vec();
    bit vb, vs, sy;
    vb = (m_vcnt < 16);
    vs = (m_vcnt >= 4) && (m_vcnt < 8);
    sy = ~(m_hsync ^ vs);
    return {9'(m_vcnt), m_vreset, ~m_vreset, m_hblank, ~m_hblank,
            vb, ~vb, m_hsync, vs, sy};
  endfunction

  task automatic model_reset();
    m_vcnt   = 0;
    m_hblank = 1'b1;
    m_hsync  = 1'b0;
    m_vreset = 1'b0;
  endtask

  // One clock: capture applied inputs, advance model, compare #1 after edge.
  task automatic step();
    bit hr, a16, a32, a64;
    hr  = hreset;
    a16 = h16;
    a32 = h32;
    a64 = h64;
    @(posedge clk);
    #1;
    cyc_no++;
    if (reset) begin
      model_reset();
    end else begin
      m_hsync = m_hblank & a32 & ~a64;
      if (hr) begin
        m_vreset = (m_vcnt == 261);
        m_vcnt   = (m_vcnt + 1) % 262;
        m_hblank = 1'b1;
      end else begin
        m_vreset = 1'b0;
        if (a16 && a64) m_hblank = 1'b0;
      end
    end
    chk("model", 32'(dut_vec), 32'(model_vec()));
  endtask

  task automatic drive(input bit hr, input bit a16, input bit a32, input bit a64);
    hreset = hr;
    h16    = a16;
    h32    = a32;
    h64    = a64;
    step();
  endtask

  // Horizontal counter position k within a line; hreset sampled at k = 0.
  task automatic hpos(input int k);
    drive(k == 0, k[4], k[5], k[6]);
  endtask

  // Assert reset away from any clock edge and check the outputs at once.
  task automatic async_reset_pulse(input bit release_now);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset", 32'(dut_vec), 32'(RESET_VEC));
    if (release_now) begin
      #1;
      reset = 1'b0;
    end
  endtask

  typedef struct {
    bit hr;
    bit a16;
    bit a32;
    bit a64;
    int e_vcnt;
    bit e_hblank;
    bit e_hsync;
    bit e_vsync;
    bit e_vblank;
    bit e_vreset;
    bit e_sync;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int hb_cnt, hb_first, hs_cnt, hs_first, hs_late, vr_seen;
    int w1, w2, vb_cnt, vs_cnt, syn_hi, vr_cnt, wrap_bad;
    logic [5:0] got_flags, exp_flags;

    //          hr a16 a32 a64 vcnt hb hs vs vb vr sync
    tbl[0] = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1};
    tbl[1] = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 0, 1};
    tbl[2] = '{0, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0};
    tbl[3] = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 1};
    tbl[4] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1};
    tbl[5] = '{1, 0, 0, 0, 2, 1, 0, 0, 1, 0, 1};
    tbl[6] = '{1, 0, 0, 0, 3, 1, 0, 0, 1, 0, 1};
    tbl[7] = '{1, 0, 0, 0, 4, 1, 0, 1, 1, 0, 0};
    tbl[8] = '{0, 0, 1, 0, 4, 1, 1, 1, 1, 0, 1};
    tbl[9] = '{1, 1, 0, 1, 5, 1, 0, 1, 1, 0, 0};

    reset  = 1'b1;
    hreset = 1'b0;
    h16    = 1'b0;
    h32    = 1'b0;
    h64    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(dut_vec), 32'(RESET_VEC));
    reset = 1'b0;

    // Table-driven vectors, including the simultaneous set/clear edge.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].hr, tbl[i].a16, tbl[i].a32, tbl[i].a64);
      chk($sformatf("tbl%0d_vcnt", i), 32'(vcnt), 32'(tbl[i].e_vcnt));
      got_flags = {hblank, hsync, vsync, vblank, vreset, sync_n};
      exp_flags = {tbl[i].e_hblank, tbl[i].e_hsync, tbl[i].e_vsync,
                   tbl[i].e_vblank, tbl[i].e_vreset, tbl[i].e_sync};
      chk($sformatf("tbl%0d_flags", i), 32'(got_flags), 32'(exp_flags));
    end

    // Held hreset: bring vcnt to 10, then hold three clocks.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
    end
    chk("held_start_vcnt", 32'(vcnt), 32'd10);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("held_end_vcnt", 32'(vcnt), 32'd13);

    // Mid-frame reset at vcnt = 100 with hblank low.
    for (int i = 0; i < 87; i++) drive(1, 0, 0, 0);
    drive(0, 1, 0, 1);
    chk("pre_reset_vcnt", 32'(vcnt), 32'd100);
    chk("pre_reset_hblank", 32'(hblank), 32'd0);
    async_reset_pulse(1'b0);
    hreset = 1'b0;
    h16    = 1'b0;
    h64    = 1'b0;
    step();
    reset = 1'b0;
    vr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      vr_seen += int'(vreset);
      drive(0, 0, 0, 0);
      vr_seen += int'(vreset);
    end
    chk("restart_vcnt", 32'(vcnt), 32'd5);
    chk("restart_vblank", 32'(vblank), 32'd1);
    chk("restart_no_vreset", 32'(vr_seen), 32'd0);

    // Horizontal timing over a full 455-clock line (second line measured).
    for (int k = 0; k < 455; k++) hpos(k);
    hb_cnt = 0; hb_first = -1; hs_cnt = 0; hs_first = -1; hs_late = 0;
    for (int k = 0; k < 455; k++) begin
      hpos(k);
      if (hblank) begin
        hb_cnt++;
        if (hb_first < 0) hb_first = k;
      end
      if (hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
        if (k >= 160 && k <= 191) hs_late++;
      end
    end
    chk("hblank_rise_k", 32'(hb_first), 32'd0);
    chk("hblank_clocks", 32'(hb_cnt), 32'd80);
    chk("hsync_offset", 32'(hs_first - hb_first), 32'd32);
    chk("hsync_clocks", 32'(hs_cnt), 32'd32);
    chk("hsync_h160_191", 32'(hs_late), 32'd0);

    // Fast-forward with held hreset, then run 128-clock lines across a
    // whole frame between two wraps.
    for (int i = 0; i < 600 && m_vcnt != 250; i++) drive(1, 0, 0, 0);
    chk("ff_vcnt", 32'(vcnt), 32'd250);
    w1 = -1; w2 = -1; vb_cnt = 0; vs_cnt = 0; syn_hi = 0; vr_cnt = 0; wrap_bad = 0;
    for (int ln = 0; ln < 300 && w2 < 0; ln++) begin
      for (int k = 0; k < 128; k++) begin
        hpos(k);
        if (vreset && vcnt != 9'd0) wrap_bad++;
        if (vreset) begin
          if (w1 < 0) w1 = cyc_no;
          else if (w2 < 0) w2 = cyc_no;
        end
        if (w1 >= 0 && w2 < 0) begin
          vb_cnt += int'(vblank);
          vs_cnt += int'(vsync);
          if (vsync) syn_hi += int'(sync_n);
          vr_cnt += int'(vreset);
        end
      end
    end
    chk("wrap_seen", 32'(w2 >= 0), 32'd1);
    chk("frame_period", 32'(w2 - w1), 32'(262 * 128));
    chk("vreset_width", 32'(vr_cnt), 32'd1);
    chk("vreset_vcnt0", 32'(wrap_bad), 32'd0);
    chk("vblank_clocks", 32'(vb_cnt), 32'(16 * 128));
    chk("vsync_clocks", 32'(vs_cnt), 32'(4 * 128));
    chk("serration_clocks", 32'(syn_hi), 32'(4 * 32));

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset_pulse(1'b1);
      drive($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
